// File: rtl/superio_arb_pkg.sv
// Shared definitions for the SuperIO register arbiter.
// Addresses, FSM states and grant encoding.
package superio_arb_pkg;

    localparam logic [2:0] ADDR_REG1  = 3'b001;
    localparam logic [2:0] ADDR_REG2  = 3'b100;
    localparam logic [2:0] ADDR_REG3  = 3'b101;
    localparam logic [2:0] ADDR_STATS = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    typedef enum logic {
        G_AVS,
        G_ISA
    } grant_t;

endpackage

// File: rtl/superio_reg_arbiter_if.sv
// Requester-side bus bundle: Avalon-MM slave port plus ISA bridge.
// master = requesters, slave = arbiter.
interface superio_reg_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       avs_address;
    logic             avs_read;
    logic             avs_write;
    logic [WIDTH-1:0] avs_writedata;
    logic [WIDTH-1:0] avs_readdata;
    logic             avs_waitrequest;
    logic             isa_req;
    logic             isa_we;
    logic [2:0]       isa_addr;
    logic [WIDTH-1:0] isa_wdata;
    logic [WIDTH-1:0] isa_rdata;
    logic             isa_ack;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        output isa_req, isa_we, isa_addr, isa_wdata,
        input  avs_readdata, avs_waitrequest, isa_rdata, isa_ack
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        input  isa_req, isa_we, isa_addr, isa_wdata,
        output avs_readdata, avs_waitrequest, isa_rdata, isa_ack
    );
endinterface

// File: rtl/superio_reg_bank.sv
// SuperIO shared register bank: REG1/REG2/REG3 storage,
// write decode and registered read decode (unmapped reads 0).
module superio_reg_bank
    import superio_arb_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] REG1_INIT = 32'h0000_0000,
    parameter logic [31:0] REG2_INIT = 32'h0000_0000,
    parameter logic [31:0] REG3_INIT = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] reg1_q,
    output logic [WIDTH-1:0] reg2_q,
    output logic [WIDTH-1:0] reg3_q
);

    // Register storage; writes to unmapped addresses are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg1_q <= WIDTH'(REG1_INIT);
            reg2_q <= WIDTH'(REG2_INIT);
            reg3_q <= WIDTH'(REG3_INIT);
        end else if (wr_en) begin
            unique case (1'b1)
                (addr == ADDR_REG1): reg1_q <= wdata;
                (addr == ADDR_REG2): reg2_q <= wdata;
                (addr == ADDR_REG3): reg3_q <= wdata;
                default: ;
            endcase
        end
    end

    // Read data captured once per read access and held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            unique case (1'b1)
                (addr == ADDR_REG1): rdata <= reg1_q;
                (addr == ADDR_REG2): rdata <= reg2_q;
                (addr == ADDR_REG3): rdata <= reg3_q;
                default:             rdata <= '0;
            endcase
        end
    end

endmodule

// File: rtl/superio_reg_arbiter.sv
// Round-robin arbiter between Avalon and ISA for the SuperIO register bank.
// Optional access counters at 3'b110 when SUPERIO_ARB_STATS_EN is defined.
module superio_reg_arbiter
    import superio_arb_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] REG1_INIT = 32'h0000_0000,
    parameter logic [31:0] REG2_INIT = 32'h0000_0000,
    parameter logic [31:0] REG3_INIT = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    superio_reg_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]      reg1_q,
    output logic [WIDTH-1:0]      reg2_q,
    output logic [WIDTH-1:0]      reg3_q
);

    state_t           state;
    state_t           state_nx;
    grant_t           grant;
    grant_t           last_grant;
    logic             grant_avs;
    logic             grant_isa;
    logic             avs_req;
    logic [2:0]       addr;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] bank_rdata;
    logic [WIDTH-1:0] rdata;

    assign avs_req = bus.avs_read | bus.avs_write;

    // Next state and grant choice; ties go to the side not served last.
    always_comb begin
        state_nx  = state;
        grant_avs = 1'b0;
        grant_isa = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (avs_req && (!bus.isa_req || last_grant == G_ISA))
                    grant_avs = 1'b1;
                else if (bus.isa_req)
                    grant_isa = 1'b1;
                if (grant_avs || grant_isa)
                    state_nx = S_ACCESS;
            end
            S_ACCESS: state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State register and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= G_ISA;
        end else begin
            state <= state_nx;
            if (state == S_DONE)
                last_grant <= grant;
        end
    end

    // Latch the winning request at grant; both strobes high means write.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant <= G_ISA;
            addr  <= '0;
            we    <= 1'b0;
            wdata <= '0;
        end else if (grant_avs) begin
            grant <= G_AVS;
            addr  <= bus.avs_address;
            we    <= bus.avs_write;
            wdata <= bus.avs_writedata;
        end else if (grant_isa) begin
            grant <= G_ISA;
            addr  <= bus.isa_addr;
            we    <= bus.isa_we;
            wdata <= bus.isa_wdata;
        end
    end

    assign wr_en = (state == S_ACCESS) && we;
    assign rd_en = (state == S_ACCESS) && !we;

    superio_reg_bank #(
        .WIDTH     (WIDTH),
        .REG1_INIT (REG1_INIT),
        .REG2_INIT (REG2_INIT),
        .REG3_INIT (REG3_INIT)
    ) u_bank (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (bank_rdata),
        .reg1_q (reg1_q),
        .reg2_q (reg2_q),
        .reg3_q (reg3_q)
    );

`ifdef SUPERIO_ARB_STATS_EN
    logic [15:0]      avs_cnt;
    logic [15:0]      isa_cnt;
    logic [WIDTH-1:0] stats_rdata;
    logic             stats_hit;

    assign stats_hit = (addr == ADDR_STATS);

    // Saturating per-side completion counters; a write to 3'b110 clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            avs_cnt     <= '0;
            isa_cnt     <= '0;
            stats_rdata <= '0;
        end else begin
            if (rd_en)
                stats_rdata <= stats_hit ? WIDTH'({isa_cnt, avs_cnt}) : '0;
            if (wr_en && stats_hit) begin
                avs_cnt <= '0;
                isa_cnt <= '0;
            end else if (state == S_DONE && !(we && stats_hit)) begin
                if (grant == G_AVS && avs_cnt != 16'hFFFF)
                    avs_cnt <= avs_cnt + 16'd1;
                if (grant == G_ISA && isa_cnt != 16'hFFFF)
                    isa_cnt <= isa_cnt + 16'd1;
            end
        end
    end

    assign rdata = bank_rdata | stats_rdata;
`else
    assign rdata = bank_rdata;
`endif

    assign bus.avs_waitrequest = !(state == S_DONE && grant == G_AVS);
    assign bus.isa_ack         = (state == S_DONE) && (grant == G_ISA);
    assign bus.avs_readdata    = rdata;
    assign bus.isa_rdata       = rdata;

endmodule

// File: tb/tb_superio_reg_arbiter.sv
// Directed testbench for superio_reg_arbiter.
// Define SUPERIO_ARB_STATS_EN to exercise the counter block.
module tb_superio_reg_arbiter;

    localparam logic [31:0] R1I = 32'hA5A5_0001;
    localparam logic [31:0] R2I = 32'h0000_0002;
    localparam logic [31:0] R3I = 32'h3333_0003;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] reg1_q, reg2_q, reg3_q;
    int          tests = 0;
    int          fails = 0;

    superio_reg_arbiter_if #(.WIDTH(32)) bus ();

    superio_reg_arbiter #(
        .WIDTH     (32),
        .REG1_INIT (R1I),
        .REG2_INIT (R2I),
        .REG3_INIT (R3I)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .reg1_q (reg1_q),
        .reg2_q (reg2_q),
        .reg3_q (reg3_q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic avs_xfer(input logic [2:0] a, input logic wr,
                            input logic [31:0] d,
                            output logic [31:0] rd, output int lat);
        bus.avs_address   = a;
        bus.avs_write     = wr;
        bus.avs_read      = !wr;
        bus.avs_writedata = d;
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!bus.avs_waitrequest) begin
                lat = i;
                rd  = bus.avs_readdata;
                break;
            end
        end
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
        tick();
    endtask

    task automatic isa_xfer(input logic [2:0] a, input logic wr,
                            input logic [31:0] d,
                            output logic [31:0] rd, output int lat);
        bus.isa_addr  = a;
        bus.isa_we    = wr;
        bus.isa_wdata = d;
        bus.isa_req   = 1'b1;
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.isa_ack) begin
                lat = i;
                rd  = bus.isa_rdata;
                break;
            end
        end
        bus.isa_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.avs_waitrequest !== 1'b1) begin
            fails++; $display("FAIL reset_wait: got %b want 1", bus.avs_waitrequest);
        end
        tests++;
        if (bus.avs_readdata !== 32'h0 || bus.isa_rdata !== 32'h0) begin
            fails++; $display("FAIL reset_rdata: got %h/%h want 0", bus.avs_readdata, bus.isa_rdata);
        end
        tests++;
        if (bus.isa_ack !== 1'b0) begin
            fails++; $display("FAIL reset_ack: got %b want 0", bus.isa_ack);
        end
        tests++;
        if (reg1_q !== R1I || reg2_q !== R2I || reg3_q !== R3I) begin
            fails++; $display("FAIL reset_regs: got %h %h %h want %h %h %h",
                              reg1_q, reg2_q, reg3_q, R1I, R2I, R3I);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (bus.avs_waitrequest !== 1'b1) begin
            fails++; $display("FAIL idle_wait: got %b want 1", bus.avs_waitrequest);
        end
    endtask

    task automatic test_avs_write();
        bus.avs_address   = 3'b100;
        bus.avs_writedata = 32'hDEAD_BEEF;
        bus.avs_write     = 1'b1;
        tick();
        tests++;
        if (bus.avs_waitrequest !== 1'b1 || reg2_q !== R2I) begin
            fails++; $display("FAIL avs_wr_c1: wait %b reg2 %h want 1 %h",
                              bus.avs_waitrequest, reg2_q, R2I);
        end
        tick();
        tests++;
        if (bus.avs_waitrequest !== 1'b0 || reg2_q !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL avs_wr_c2: wait %b reg2 %h want 0 deadbeef",
                              bus.avs_waitrequest, reg2_q);
        end
        bus.avs_write = 1'b0;
        tick();
        tests++;
        if (bus.avs_waitrequest !== 1'b1) begin
            fails++; $display("FAIL avs_wr_c3: wait %b want 1", bus.avs_waitrequest);
        end
    endtask

    task automatic test_isa_read();
        bus.isa_addr = 3'b100;
        bus.isa_we   = 1'b0;
        bus.isa_req  = 1'b1;
        tick();
        tests++;
        if (bus.isa_ack !== 1'b0) begin
            fails++; $display("FAIL isa_rd_c1: ack %b want 0", bus.isa_ack);
        end
        tick();
        tests++;
        if (bus.isa_ack !== 1'b1 || bus.isa_rdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL isa_rd_c2: ack %b data %h want 1 deadbeef",
                              bus.isa_ack, bus.isa_rdata);
        end
        bus.isa_req = 1'b0;
        tick();
        tests++;
        if (bus.isa_ack !== 1'b0) begin
            fails++; $display("FAIL isa_rd_pulse: ack %b want 0", bus.isa_ack);
        end
    endtask

    task automatic test_avs_read();
        logic [31:0] rd;
        int lat;
        avs_xfer(3'b101, 1'b0, 32'h0, rd, lat);
        tests++;
        if (lat != 2 || rd !== R3I) begin
            fails++; $display("FAIL avs_rd: lat %0d data %h want 2 %h", lat, rd, R3I);
        end
    endtask

    task automatic test_tie();
        do_reset();
        bus.avs_address   = 3'b001;
        bus.avs_writedata = 32'h11;
        bus.avs_write     = 1'b1;
        bus.isa_addr      = 3'b101;
        bus.isa_wdata     = 32'h22;
        bus.isa_we        = 1'b1;
        bus.isa_req       = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.avs_waitrequest !== 1'b0 || bus.isa_ack !== 1'b0 || reg1_q !== 32'h11) begin
            fails++; $display("FAIL tie1_avs: wait %b ack %b reg1 %h want 0 0 11",
                              bus.avs_waitrequest, bus.isa_ack, reg1_q);
        end
        bus.avs_writedata = 32'h77;
        tick();
        tick();
        tick();
        tests++;
        if (bus.isa_ack !== 1'b1 || bus.avs_waitrequest !== 1'b1 || reg3_q !== 32'h22) begin
            fails++; $display("FAIL tie1_isa: ack %b wait %b reg3 %h want 1 1 22",
                              bus.isa_ack, bus.avs_waitrequest, reg3_q);
        end
        bus.isa_req = 1'b0;
        tick();
        tick();
        tick();
        tests++;
        if (bus.avs_waitrequest !== 1'b0 || reg1_q !== 32'h77) begin
            fails++; $display("FAIL tie1_avs2: wait %b reg1 %h want 0 77",
                              bus.avs_waitrequest, reg1_q);
        end
        bus.avs_write = 1'b0;
        tick();
        bus.avs_address   = 3'b100;
        bus.avs_writedata = 32'h33;
        bus.avs_write     = 1'b1;
        bus.isa_addr      = 3'b101;
        bus.isa_wdata     = 32'h44;
        bus.isa_req       = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.isa_ack !== 1'b1 || bus.avs_waitrequest !== 1'b1 ||
            reg3_q !== 32'h44 || reg2_q !== R2I) begin
            fails++; $display("FAIL tie2_isa: ack %b wait %b reg3 %h reg2 %h want 1 1 44 %h",
                              bus.isa_ack, bus.avs_waitrequest, reg3_q, reg2_q, R2I);
        end
        bus.isa_req = 1'b0;
        tick();
        tick();
        tick();
        tests++;
        if (bus.avs_waitrequest !== 1'b0 || reg2_q !== 32'h33) begin
            fails++; $display("FAIL tie2_avs: wait %b reg2 %h want 0 33",
                              bus.avs_waitrequest, reg2_q);
        end
        bus.avs_write = 1'b0;
        tick();
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        int lat;
        isa_xfer(3'b011, 1'b1, 32'h1234, rd, lat);
        tests++;
        if (lat != 2) begin
            fails++; $display("FAIL unmap_wr_lat: got %0d want 2", lat);
        end
        tests++;
        if (reg1_q !== 32'h77 || reg2_q !== 32'h33 || reg3_q !== 32'h44) begin
            fails++; $display("FAIL unmap_regs: got %h %h %h want 77 33 44",
                              reg1_q, reg2_q, reg3_q);
        end
        isa_xfer(3'b001, 1'b0, 32'h0, rd, lat);
        tests++;
        if (lat != 2 || rd !== 32'h77) begin
            fails++; $display("FAIL isa_rd_reg1: lat %0d data %h want 2 77", lat, rd);
        end
        isa_xfer(3'b011, 1'b0, 32'h0, rd, lat);
        tests++;
        if (lat != 2 || rd !== 32'h0) begin
            fails++; $display("FAIL unmap_rd: lat %0d data %h want 2 0", lat, rd);
        end
        avs_xfer(3'b001, 1'b0, 32'h0, rd, lat);
        avs_xfer(3'b111, 1'b0, 32'h0, rd, lat);
        tests++;
        if (lat != 2 || rd !== 32'h0) begin
            fails++; $display("FAIL unmap_avs_rd: lat %0d data %h want 2 0", lat, rd);
        end
    endtask

    task automatic test_both_strobes();
        bus.avs_address   = 3'b101;
        bus.avs_writedata = 32'hCAFE;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.avs_waitrequest !== 1'b0 || reg3_q !== 32'hCAFE) begin
            fails++; $display("FAIL rw_as_write: wait %b reg3 %h want 0 cafe",
                              bus.avs_waitrequest, reg3_q);
        end
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
        tick();
    endtask

    task automatic test_reset_midaccess();
        bus.avs_address   = 3'b001;
        bus.avs_writedata = 32'h55;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_write = 1'b0;
        reset = 1'b1;
        tick();
        tests++;
        if (reg1_q !== R1I || bus.avs_waitrequest !== 1'b1 || bus.isa_ack !== 1'b0) begin
            fails++; $display("FAIL rst_mid_a: reg1 %h wait %b ack %b want %h 1 0",
                              reg1_q, bus.avs_waitrequest, bus.isa_ack, R1I);
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        tests++;
        if (reg1_q !== R1I || bus.avs_waitrequest !== 1'b1 || bus.isa_ack !== 1'b0) begin
            fails++; $display("FAIL rst_mid_b: reg1 %h wait %b ack %b want %h 1 0",
                              reg1_q, bus.avs_waitrequest, bus.isa_ack, R1I);
        end
    endtask

`ifdef SUPERIO_ARB_STATS_EN
    task automatic test_stats();
        logic [31:0] rd;
        int lat;
        do_reset();
        avs_xfer(3'b001, 1'b1, 32'h1, rd, lat);
        avs_xfer(3'b100, 1'b1, 32'h2, rd, lat);
        avs_xfer(3'b101, 1'b0, 32'h0, rd, lat);
        isa_xfer(3'b101, 1'b1, 32'h3, rd, lat);
        isa_xfer(3'b001, 1'b0, 32'h0, rd, lat);
        avs_xfer(3'b110, 1'b0, 32'h0, rd, lat);
        tests++;
        if (lat != 2 || rd !== 32'h0002_0003) begin
            fails++; $display("FAIL stats_rd: lat %0d data %h want 2 00020003", lat, rd);
        end
        avs_xfer(3'b110, 1'b1, 32'hFFFF_FFFF, rd, lat);
        avs_xfer(3'b110, 1'b0, 32'h0, rd, lat);
        tests++;
        if (rd !== 32'h0) begin
            fails++; $display("FAIL stats_clr: data %h want 0", rd);
        end
        avs_xfer(3'b110, 1'b0, 32'h0, rd, lat);
        tests++;
        if (rd !== 32'h0000_0001) begin
            fails++; $display("FAIL stats_after_clr: data %h want 1", rd);
        end
    endtask
`else
    task automatic test_stats();
        logic [31:0] rd;
        int lat;
        avs_xfer(3'b110, 1'b1, 32'h9999, rd, lat);
        avs_xfer(3'b110, 1'b0, 32'h0, rd, lat);
        tests++;
        if (lat != 2 || rd !== 32'h0) begin
            fails++; $display("FAIL stats_absent: lat %0d data %h want 2 0", lat, rd);
        end
        tests++;
        if (reg1_q !== R1I || reg2_q !== R2I || reg3_q !== R3I) begin
            fails++; $display("FAIL stats_absent_regs: got %h %h %h", reg1_q, reg2_q, reg3_q);
        end
    endtask
`endif

    initial begin
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.isa_req       = 1'b0;
        bus.isa_we        = 1'b0;
        bus.isa_addr      = '0;
        bus.isa_wdata     = '0;
        test_reset();
        test_avs_write();
        test_isa_read();
        test_avs_read();
        test_tie();
        test_unmapped();
        test_both_strobes();
        test_reset_midaccess();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
